// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side drain engine for a dual-clock FIFO. Pops words
//                through the show-ahead rempty/rinc/rdata port and presents
//                them as a valid/ready stream through a registered 2-entry
//                skid buffer. m_last flags every BURST_LEN-th accepted beat.
//                The pop strobe depends only on registered occupancy, en and
//                rempty, so m_ready never reaches the FIFO pointer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             en,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             busy
);

  // Beat index that closes a burst.
  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Occupancy encodings of the head + skid pair.
  localparam logic [1:0] c_OCC_EMPTY = 2'd0;
  localparam logic [1:0] c_OCC_ONE   = 2'd1;
  localparam logic [1:0] c_OCC_FULL  = 2'd2;

  logic [1:0]       occ_q,   occ_d;
  logic [DSIZE-1:0] head_q,  head_d;
  logic [DSIZE-1:0] skid_q,  skid_d;
  logic [CNT_W-1:0] beat_q,  beat_d;
  logic             valid_q, valid_d;
  logic             last_q,  last_d;

  logic             w_pop;
  logic             w_fire;

  // Pop only when the FIFO has data and the buffer has a free slot; the
  // slot test uses registered occupancy so m_ready is not in this path.
  assign w_pop  = en && !rempty && (occ_q != c_OCC_FULL);
  assign w_fire = valid_q && m_ready;

  assign rinc     = w_pop;
  assign m_data   = head_q;
  assign m_valid  = valid_q;
  assign m_last   = last_q;
  assign beat_cnt = beat_q;
  assign busy     = valid_q;

  // Next-state: buffer occupancy, data movement and burst beat counter.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    beat_d = beat_q;

    unique case (occ_q)
      c_OCC_EMPTY: begin
        if (w_pop) begin
          head_d = rdata;
          occ_d  = c_OCC_ONE;
        end
      end
      c_OCC_ONE: begin
        if (w_pop && w_fire) begin
          // Head leaves while the new word replaces it: steady-state path.
          head_d = rdata;
        end else if (w_pop) begin
          skid_d = rdata;
          occ_d  = c_OCC_FULL;
        end else if (w_fire) begin
          occ_d  = c_OCC_EMPTY;
        end
      end
      c_OCC_FULL: begin
        // No pop is possible here; a fire promotes the skid word.
        if (w_fire) begin
          head_d = skid_q;
          occ_d  = c_OCC_ONE;
        end
      end
      default: begin
        occ_d = c_OCC_EMPTY;
      end
    endcase

    if (w_fire) begin
      if (beat_q == c_LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end

    // Stream flags are precomputed so they leave the block from flops.
    valid_d = (occ_d != c_OCC_EMPTY);
    last_d  = valid_d && (beat_d == c_LAST_BEAT);
  end

  // State registers; reset discards buffered words and restarts the burst.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q   <= c_OCC_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Self-checking bench for fifo_rd_stream. A word-level model
//                (source queue, in-flight scoreboard, accepted-beat count)
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int BL = 16;

  logic       rclk;
  logic       rrst_n;
  logic [7:0] rdata;
  logic       rempty;
  logic       rinc;
  logic       en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [3:0] beat_cnt;
  logic       busy;

  fifo_rd_stream #(.DSIZE(8), .BURST_LEN(BL), .CNT_W(4)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .en       (en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .beat_cnt (beat_cnt),
    .busy     (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int ncmp  = 0;
  int nfail = 0;

  // Word-level model state.
  logic [7:0] src[$];      // words still in the FIFO
  logic [7:0] sb[$];       // words popped but not yet accepted downstream
  int         acc;         // beats accepted since last reset
  int         last_pos[$]; // beat numbers at which m_last accompanied a fire
  logic       en_v;
  logic       rdy_v;
  int         empty_pct;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rempty;
    logic [7:0] rdata;
    logic       exp_rinc;
    logic       exp_valid;
    logic       chk_data;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the low phase, check, advance model.
  task automatic step();
    logic exp_rinc;
    logic fire;
    int   infl;
    infl   = sb.size();
    rempty = (src.size() == 0) || (empty_pct > 0 && $urandom_range(0, 99) < empty_pct);
    rdata  = (src.size() != 0) ? src[0] : 8'h00;
    en      = en_v;
    m_ready = rdy_v;
    #1;
    exp_rinc = en_v && !rempty && (infl < 2);
    chk("rinc", rinc, exp_rinc);
    chk("no_underflow", rinc & rempty, 0);
    chk("m_valid", m_valid, infl != 0);
    chk("busy", busy, infl != 0);
    chk("beat_cnt", beat_cnt, acc % BL);
    chk("m_last", m_last, (infl != 0) && ((acc % BL) == BL - 1));
    if (infl != 0) chk("m_data", m_data, sb[0]);
    fire = (infl != 0) && rdy_v;
    if (fire) begin
      if (m_last) last_pos.push_back(acc + 1);
      void'(sb.pop_front());
      acc++;
    end
    if (exp_rinc) sb.push_back(src.pop_front());
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic run_until(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (acc < target && n < budget) begin
      step();
      n++;
    end
    if (acc < target) chk({nm, "_timeout"}, acc, target);
  endtask

  // Reset with en low; checks the reset values and clears the model buffer.
  task automatic do_reset();
    en_v = 1'b0; rdy_v = 1'b0;
    en = 1'b0; m_ready = 1'b0;
    rrst_n = 1'b0;
    #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    sb.delete();
    last_pos.delete();
    acc = 0;
  endtask

  initial begin
    int fires;
    tv[0] = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 4'd0};
    tv[1] = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 4'd0};
    tv[2] = '{1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 4'd1};
    tv[3] = '{1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 4'd2};
    tv[4] = '{1'b1, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 4'd3};
    tv[5] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 4'd4};
    tv[6] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd5};

    rrst_n = 1'b0; en = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = 8'h00;
    empty_pct = 0; acc = 0;
    @(negedge rclk);

    // Test 1: five preloaded words, fixed expected-output table.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      en = tv[i].en; m_ready = tv[i].rdy; rempty = tv[i].rempty; rdata = tv[i].rdata;
      #1;
      chk($sformatf("t1_rinc[%0d]", i), rinc, tv[i].exp_rinc);
      chk($sformatf("t1_valid[%0d]", i), m_valid, tv[i].exp_valid);
      chk($sformatf("t1_busy[%0d]", i), busy, tv[i].exp_valid);
      chk($sformatf("t1_last[%0d]", i), m_last, tv[i].exp_last);
      chk($sformatf("t1_cnt[%0d]", i), beat_cnt, tv[i].exp_cnt);
      if (tv[i].chk_data) chk($sformatf("t1_data[%0d]", i), m_data, tv[i].exp_data);
      @(posedge rclk);
      @(negedge rclk);
    end

    // Test 2: 40 continuous words, m_last on beats 16 and 32, no gaps.
    do_reset();
    for (int i = 0; i < 40; i++) src.push_back(8'(i + 8'h10));
    en_v = 1'b1; rdy_v = 1'b1;
    begin
      int cyc;
      int vcyc;
      cyc = 0; vcyc = 0;
      while (acc < 40 && cyc < 200) begin
        if (m_valid) vcyc++;
        step();
        cyc++;
      end
      chk("t2_cycles", cyc, 41);
      chk("t2_valid_cycles", vcyc, 40);
    end
    chk("t2_nlast", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("t2_last0", last_pos[0], 16);
      chk("t2_last1", last_pos[1], 32);
    end
    chk("t2_final_cnt", beat_cnt, 8);

    // Test 3: six cycles of backpressure, then drain in order.
    do_reset();
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(8'(8'hA0 + i));
    en_v = 1'b1; rdy_v = 1'b1;
    repeat (3) step();
    rdy_v = 1'b0;
    repeat (6) step();
    chk("t3_rinc_blocked", rinc, 0);
    chk("t3_valid_held", m_valid, 1);
    chk("t3_inflight", sb.size(), 2);
    rdy_v = 1'b1;
    run_until(10, 100, "t3");
    chk("t3_src_drained", src.size(), 0);

    // Test 4: 1000 random words with random ready and random empty.
    do_reset();
    src.delete();
    for (int i = 0; i < 1000; i++) src.push_back(8'($urandom));
    en_v = 1'b1; empty_pct = 30;
    begin
      int n;
      n = 0;
      while (acc < 1000 && n < 20000) begin
        rdy_v = 1'($urandom_range(0, 1));
        step();
        n++;
      end
    end
    chk("t4_accepted", acc, 1000);
    chk("t4_nlast", last_pos.size(), 1000 / BL);
    empty_pct = 0;

    // Test 5: en dropped after beat 5 for ten cycles.
    do_reset();
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(8'(8'h40 + i));
    en_v = 1'b1; rdy_v = 1'b1;
    run_until(5, 50, "t5a");
    en_v = 1'b0;
    fires = acc;
    repeat (10) step();
    fires = acc - fires;
    chk("t5_drain_le2", fires <= 2, 1);
    chk("t5_idle_valid", m_valid, 0);
    chk("t5_cnt_held", beat_cnt, 5 + fires);
    en_v = 1'b1;
    run_until(20, 100, "t5b");
    chk("t5_nlast", last_pos.size(), 1);
    if (last_pos.size() == 1) chk("t5_last_pos", last_pos[0], 16);

    // Test 6: asynchronous reset with two words buffered at beat 9.
    do_reset();
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(8'(8'hC0 + i));
    en_v = 1'b1; rdy_v = 1'b1;
    run_until(9, 50, "t6a");
    rdy_v = 1'b0;
    repeat (3) step();
    m_ready = 1'b0;
    #1;
    chk("t6_pre_cnt", beat_cnt, 9);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_rinc", rinc, 0);
    #1;
    rrst_n = 1'b0;
    #1;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_async_last", m_last, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_cnt", beat_cnt, 0);
    sb.delete();
    last_pos.delete();
    acc = 0;
    @(negedge rclk);
    rrst_n = 1'b1;
    rdy_v = 1'b1;
    run_until(5, 50, "t6b");
    chk("t6_nlast", last_pos.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
